// File: rtl/pi_frame_tx_if.sv
// Bus bundle between the effects stage and the Pi frame transmitter.
// The master drives sample strobes and overrun clear; the slave (transmitter) drives the SPI lines and status.
`timescale 1ns/1ps
interface pi_frame_tx_if;
    logic        sample_valid;
    logic [10:0] sample;
    logic        overrun_clr;
    logic        sclk;
    logic        dout;
    logic        ncs;
    logic        busy;
    logic        overrun;

    modport master (
        output sample_valid, sample, overrun_clr,
        input  sclk, dout, ncs, busy, overrun
    );

    modport slave (
        input  sample_valid, sample, overrun_clr,
        output sclk, dout, ncs, busy, overrun
    );
endinterface

// File: rtl/pi_frame_tx.sv
// pi_frame_tx: framed SPI (mode 0) transmitter carrying sign-magnitude samples to the Raspberry Pi.
// Define PI_FRAME_PARITY_EN to place even parity over bits 15:1 in bit 0; otherwise bit 0 is 0.
`timescale 1ns/1ps
module pi_frame_tx #(
    parameter int SCLK_HALF = 16,
    parameter int GUARD     = 32
) (
    input  logic         clk,
    input  logic         reset,
    pi_frame_tx_if.slave bus
);
    localparam int CNT_MAX = (SCLK_HALF > GUARD) ? SCLK_HALF : GUARD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

`ifdef PI_FRAME_PARITY_EN
    function automatic logic frame_parity(input logic [14:0] bits);
        return ^bits;
    endfunction
`endif

    function automatic logic [15:0] build_frame(input logic [10:0] smp, input logic seq);
        logic [15:0] f;
        f = {3'b101, smp, seq, 1'b0};
`ifdef PI_FRAME_PARITY_EN
        f[0] = frame_parity(f[15:1]);
`endif
        return f;
    endfunction

    state_t        state_q;
    logic [14:0]   shreg_q;
    logic [3:0]    bit_q;
    logic [CW-1:0] cnt_q;
    logic          sclk_q;
    logic          dout_q;
    logic          ncs_q;
    logic          busy_q;
    logic          seq_q;
    logic [10:0]   pend_q;
    logic          pend_valid_q;
    logic          overrun_q;

    logic          hold_end;
    logic          consume;
    logic          direct_load;
    logic          start_frame;
    logic          store;
    logic          ovr_event;
    logic [10:0]   load_sample;
    logic [15:0]   load_frame;
    logic          pend_valid_d;
    logic          overrun_d;

    // Frame-start decision and pending-slot bookkeeping; a HOLD-exit consume frees the slot for a same-cycle strobe.
    always_comb begin
        hold_end     = (state_q == HOLD) && (cnt_q == GUARD_LAST);
        consume      = hold_end && pend_valid_q;
        direct_load  = bus.sample_valid && ((state_q == IDLE) || (hold_end && !pend_valid_q));
        start_frame  = consume || direct_load;
        store        = bus.sample_valid && busy_q && !direct_load;
        ovr_event    = store && pend_valid_q && !consume;
        load_sample  = consume ? pend_q : bus.sample;
        load_frame   = build_frame(load_sample, seq_q);
        pend_valid_d = store ? 1'b1 : (consume ? 1'b0 : pend_valid_q);
        overrun_d    = ovr_event ? 1'b1 : (bus.overrun_clr ? 1'b0 : overrun_q);
    end

    // Frame FSM: shifts 16 bits MSB first, then holds ncs high for the guard time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= 15'd0;
            bit_q   <= 4'd0;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            dout_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            seq_q   <= 1'b0;
        end else if (start_frame) begin
            state_q <= SHIFT;
            shreg_q <= load_frame[14:0];
            dout_q  <= load_frame[15];
            bit_q   <= 4'd15;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                end
                SHIFT: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else if (bit_q == 4'd0) begin
                            state_q <= HOLD;
                            sclk_q  <= 1'b0;
                            dout_q  <= 1'b0;
                            ncs_q   <= 1'b1;
                            seq_q   <= ~seq_q;
                        end else begin
                            // Next bit is presented at the start of its low phase.
                            sclk_q  <= 1'b0;
                            bit_q   <= bit_q - 4'd1;
                            dout_q  <= shreg_q[14];
                            shreg_q <= {shreg_q[13:0], 1'b0};
                        end
                    end else begin
                        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                HOLD: begin
                    if (hold_end) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    sclk_q  <= 1'b0;
                    dout_q  <= 1'b0;
                    ncs_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pending sample slot and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q       <= 11'd0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (store) begin
                pend_q <= bus.sample;
            end
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.dout    = dout_q;
    assign bus.ncs     = ncs_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_pi_frame_tx.sv
// Self-checking bench for pi_frame_tx: a cycle-level Pi receiver model pops expected frames from a scoreboard
// queue filled by a behavioural model of sample arrival, pending storage and frame scheduling.
`timescale 1ns/1ps
module tb_pi_frame_tx;
    localparam int HALF   = 16;
    localparam int GUARD  = 32;
    localparam int FRAME  = 32 * HALF;
    localparam int PERIOD = FRAME + GUARD;
`ifdef PI_FRAME_PARITY_EN
    localparam bit          PAR = 1'b1;
    localparam logic [15:0] LIT_F1 = 16'hB68C;
    localparam logic [15:0] LIT_F2 = 16'hB68F;
`else
    localparam bit          PAR = 1'b0;
    localparam logic [15:0] LIT_F1 = 16'hB68C;
    localparam logic [15:0] LIT_F2 = 16'hB68E;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    pi_frame_tx_if bus();

    pi_frame_tx #(.SCLK_HALF(HALF), .GUARD(GUARD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] exp_q[$];
    bit          m_active = 1'b0;
    int          m_start  = 0;
    bit          m_pend_v = 1'b0;
    logic [10:0] m_pend   = 11'd0;
    bit          m_seq    = 1'b0;
    bit          m_ovr    = 1'b0;

    function automatic logic [15:0] exp_frame(input logic [10:0] s, input bit sq);
        logic [15:0] f;
        f = {3'b101, s, sq, 1'b0};
        if (PAR && ($countones(f) % 2 == 1)) f[0] = 1'b1;
        return f;
    endfunction

    function automatic void emit(input logic [10:0] s);
        exp_q.push_back(exp_frame(s, m_seq));
        m_seq = ~m_seq;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_active = 1'b0; m_pend_v = 1'b0; m_seq = 1'b0; m_ovr = 1'b0;
    endfunction

    // A frame started at edge S occupies edges S..S+PERIOD-1; a waiting sample starts at S+PERIOD.
    function automatic void model_advance(input int s);
        while (m_active && m_pend_v && s >= m_start + PERIOD) begin
            m_start  = m_start + PERIOD;
            emit(m_pend);
            m_pend_v = 1'b0;
        end
        if (m_active && s > m_start + PERIOD) m_active = 1'b0;
    endfunction

    function automatic void model_strobe(input int s, input logic [10:0] smp);
        model_advance(s);
        if (m_active && s <= m_start + PERIOD - 1) begin
            if (m_pend_v) m_ovr = 1'b1;
            m_pend   = smp;
            m_pend_v = 1'b1;
        end else begin
            m_start  = s;
            m_active = 1'b1;
            emit(smp);
        end
    endfunction

    initial forever begin
        @(negedge clk);
        if (!reset) model_advance(edge_cnt + 1);
    end

    // ---------------- Pi receiver monitor ----------------
    logic [15:0] rx_sh      = 16'd0;
    logic [15:0] last_frame = 16'd0;
    int          rx_bits    = 0;
    int          rx_len     = 0;
    int          n_frames   = 0;
    logic        sclk_prev  = 1'b0;
    logic        ncs_prev   = 1'b1;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            rx_bits = 0; rx_len = 0; sclk_prev = 1'b0; ncs_prev = 1'b1;
        end else begin
            if (!bus.ncs) begin
                rx_len++;
                if (!sclk_prev && bus.sclk) begin
                    rx_sh = {rx_sh[14:0], bus.dout};
                    rx_bits++;
                end
            end
            if (!ncs_prev && bus.ncs) begin
                check("frame_len", 32'(rx_len), 32'(FRAME));
                check("frame_bits", 32'(rx_bits), 32'd16);
                if (exp_q.size() == 0) check("unexpected_frame", 32'(rx_sh), 32'hFFFF_FFFF);
                else check("frame_data", 32'(rx_sh), 32'(exp_q.pop_front()));
                last_frame = rx_sh;
                n_frames++;
                rx_len = 0; rx_bits = 0;
            end
            sclk_prev = bus.sclk;
            ncs_prev  = bus.ncs;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe_at(input int e, input logic [10:0] smp);
        while (edge_cnt < e - 1) @(negedge clk);
        bus.sample       = smp;
        bus.sample_valid = 1'b1;
        model_strobe(e, smp);
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic clear_overrun();
        bus.overrun_clr = 1'b1;
        m_ovr = 1'b0;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        check("overrun_cleared", 32'(bus.overrun), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int e;
        int f0;
        logic [10:0] base;
        bus.sample_valid = 1'b0;
        bus.sample       = 11'd0;
        bus.overrun_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ncs", 32'(bus.ncs), 32'd1);
        check("rst_sclk", 32'(bus.sclk), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single frame with timing of ncs and busy.
        e = edge_cnt + 2;
        strobe_at(e, 11'h5A3);
        check("load_ncs_low", 32'(bus.ncs), 32'd0);
        check("load_busy", 32'(bus.busy), 32'd1);
        repeat (FRAME - 1) @(negedge clk);
        check("last_bit_ncs_low", 32'(bus.ncs), 32'd0);
        @(negedge clk);
        check("hold_ncs_high", 32'(bus.ncs), 32'd1);
        check("hold_sclk_low", 32'(bus.sclk), 32'd0);
        repeat (GUARD - 1) @(negedge clk);
        check("guard_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("guard_end_busy", 32'(bus.busy), 32'd0);
        drain();
        check("frame1_literal", 32'(last_frame), 32'(LIT_F1));

        // Second frame: seq toggles.
        strobe_at(edge_cnt + 5, 11'h5A3);
        drain();
        check("frame2_literal", 32'(last_frame), 32'(LIT_F2));

        // Overrun: intermediate pending sample is replaced.
        e = edge_cnt + 2;
        strobe_at(e, 11'h155);
        strobe_at(e + 40, 11'h001);
        check("no_overrun_yet", 32'(bus.overrun), 32'd0);
        strobe_at(e + 100, 11'h7FF);
        check("overrun_set", 32'(bus.overrun), 32'd1);
        drain();
        check("overrun_sticky", 32'(bus.overrun), 32'd1);
        check("overrun_frame_last", 32'(last_frame[12:2]), 32'h7FF);
        clear_overrun();

        // Strobe exactly on the HOLD-exit cycle while a sample is pending.
        f0 = n_frames;
        e = edge_cnt + 2;
        strobe_at(e, 11'h400);
        strobe_at(e + 50, 11'h123);
        strobe_at(e + PERIOD, 11'h456);
        check("boundary_no_overrun", 32'(bus.overrun), 32'd0);
        drain();
        check("boundary_frames", 32'(n_frames - f0), 32'd3);
        check("boundary_last", 32'(last_frame[12:2]), 32'h456);

        // Reset in the high phase of bit 7.
        e = edge_cnt + 2;
        strobe_at(e, 11'h2AB);
        while (edge_cnt < e + 8 * 2 * HALF + 20) @(negedge clk);
        check("pre_reset_sclk", 32'(bus.sclk), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_ncs", 32'(bus.ncs), 32'd1);
        check("async_rst_sclk", 32'(bus.sclk), 32'd0);
        check("async_rst_dout", 32'(bus.dout), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        strobe_at(edge_cnt + 3, 11'h3C5);
        drain();
        check("post_reset_seq", 32'(last_frame[1]), 32'd0);

        // Randomized arrivals, some faster than a frame.
        e = edge_cnt + 2;
        for (int i = 0; i < 25; i++) begin
            strobe_at(e, 11'($urandom));
            check("rand_overrun", 32'(bus.overrun), 32'(m_ovr));
            if (i % 6 == 5) clear_overrun();
            e = e + int'($urandom_range(200, 1000));
        end
        drain();
        clear_overrun();

        // Periodic ramp at the nominal sample rate.
        base = 11'($urandom_range(0, 2047 - 50));
        f0 = n_frames;
        e = edge_cnt + 2;
        for (int i = 0; i < 50; i++) strobe_at(e + i * 833, base + 11'(i));
        drain();
        check("ramp_frames", 32'(n_frames - f0), 32'd50);
        check("ramp_no_overrun", 32'(bus.overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pi_frame_tx.md
Name: pi_frame_tx

Overview:
- Framed SPI transmitter that carries each processed sample (sign-magnitude) from the effects stage to the Raspberry Pi.
- Adds a sync pattern, a sequence bit and a parity bit so the Pi can detect misalignment and dropped frames.
- Holds one pending sample while a frame is in flight and flags overruns.

Parameters:
- SCLK_HALF, 16, clk cycles per sclk half-period. Default gives 1.25 MHz at 40 MHz clk.
- GUARD, 32, clk cycles ncs stays high between frames.

Ports:
- clk  in  1  system clock (40 MHz)
- reset  in  1  reset, asynchronous, active-high
- sample_valid  in  1  one-cycle strobe, once per 48 kHz sample period
- sample  in  11  sign-magnitude sample: bit10 = sign, bits9:0 = magnitude
- overrun_clr  in  1  synchronous clear of overrun
- sclk  out  1  SPI clock to Pi, mode 0 (idles low)
- dout  out  1  SPI data, MSB first
- ncs  out  1  chip select, active-low
- busy  out  1  high from frame load until the end of GUARD
- overrun  out  1  sticky: a sample was overwritten before transmission

Behaviour:
- Reset values: ncs=1, sclk=0, dout=0, busy=0, overrun=0; pending empty; seq=0; state IDLE. Reset mid-frame aborts the frame immediately.
- Frame layout, 16 bits: [15:13]=3'b101 sync; [12:2]=sample; [1]=seq; [0]=parity (see Optional Feature).
- seq toggles after each completed frame.
- States:
  - IDLE: ncs=1, sclk=0.
  - SHIFT: 16 bits. Each bit is SCLK_HALF cycles with sclk=0, then SCLK_HALF cycles with sclk=1. dout changes only at the start of a bit's low phase; the Pi samples on sclk rise.
  - HOLD: ncs=1, sclk=0, dout=0 for GUARD cycles.
- Load: sample_valid in IDLE at cycle t causes the following at t+1: shift register loaded, ncs=0, dout=bit15, busy=1, state SHIFT.
- After the high phase of bit0, the next cycle has ncs=1, sclk=0 and state HOLD. Frame length is 32*SCLK_HALF clks (512 at default).
- At the end of HOLD:
  - pending valid: load pending directly into SHIFT (ncs falls on that cycle).
  - otherwise: go to IDLE, busy=0.
- sample_valid while busy:
  - pending empty: store in pending.
  - pending full: overwrite pending with the newest sample and set overrun.
- Same-cycle strobe and HOLD-exit consume of pending: pending is consumed and the new sample is written to pending. No overrun.
- overrun_clr and an overrun event in the same cycle: overrun stays 1.
- Default timing: 512+32 = 544 clks per frame, which is below the 833-clk sample period. Overrun occurs only if strobes arrive faster than one per 544 clks.
- sign/magnitude is passed through unaltered, including negative zero (11'h400).

Optional Feature:
- Macro PI_FRAME_PARITY_EN.
- Defined: bit0 = even parity over bits15:1 (XOR of bits15:1).
- Undefined: bit0 is constant 0 and the parity logic is not built.

Test Plan:
- Reset, then sample_valid with sample=11'h5A3 (PI_FRAME_PARITY_EN defined) -> ncs low at t+1; 16 bits captured on sclk rises = 16'hB68C; ncs high 512 clks after t+1; busy low 32 clks later.
- Second strobe with 11'h5A3 after the first frame completes -> frame 16'hB68F (seq=1, parity=1). Macro undefined -> 16'hB68E.
- Strobe at 40 clks into frame 1 (sample 11'h001), second strobe at 100 clks (sample 11'h7FF) -> overrun=1; frame 2 carries 11'h7FF; 11'h001 is never sent; overrun_clr clears the flag.
- Strobe on the exact cycle HOLD ends while pending=11'h123, new sample=11'h456 -> frames 11'h123 then 11'h456 back-to-back, overrun stays 0.
- Assert reset at bit 7 of a frame -> ncs=1, sclk=0, dout=0 in the same cycle (async). After release, the next frame has seq=0 and a full 16-bit frame.
- Periodic strobes every 833 clks for 50 samples of a ramp -> Pi model receives every sample in order, sync=101 every frame, seq alternates, overrun never set.
